cxu_gf_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one GF(2^8) multiplier CXU between NREQ requesters.
- Each requester presents a CFU-style cmd/rsp handshake. The arbiter accepts one command at a time, registers it, and issues it to the shared CXU.
- It captures the CXU response and returns it to the owning requester.
- A response watchdog protects requesters against a hung CXU.

---
 rtl/cxu_gf_arbiter.sv | 165 ++++++++++++++++
 tb/tb_cxu_gf_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cxu_gf_arbiter.sv
// Round-robin arbiter/sequencer sharing one GF(2^8) multiplier CXU between
// NREQ CFU-style requesters. One command in flight at a time; a watchdog
// forces completion with a zero result if the CXU never answers.

// Per-requester handshake decode: turns the shared grant/owner state into
// this requester's cmd_ready and rsp_valid bits.
module cxu_gf_arbiter_lane #(
  parameter int PW  = 2,
  parameter int IDX = 0
) (
  input  logic [PW-1:0] grant_idx,
  input  logic          grant_en,
  input  logic [PW-1:0] owner,
  input  logic          deliver,
  output logic          cmd_ready,
  output logic          rsp_valid
);
  assign cmd_ready = grant_en && (grant_idx == PW'(IDX));
  assign rsp_valid = deliver  && (owner     == PW'(IDX));
endmodule

module cxu_gf_arbiter #(
  parameter int NREQ     = 4,
  parameter int STATE_ID = 0,
  parameter int CXU_ID   = 0,
  parameter int TIMEOUT  = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_cmd_valid,
  output logic [NREQ-1:0]      req_cmd_ready,
  input  logic [3*NREQ-1:0]    req_function_id,
  input  logic [32*NREQ-1:0]   req_inputs_0,
  input  logic [32*NREQ-1:0]   req_inputs_1,
  output logic [NREQ-1:0]      req_rsp_valid,
  input  logic [NREQ-1:0]      req_rsp_ready,
  output logic [31:0]          req_rsp_outputs_0,
  output logic                 cxu_cmd_valid,
  input  logic                 cxu_cmd_ready,
  output logic [2:0]           cxu_cmd_payload_function_id,
  output logic [31:0]          cxu_cmd_payload_inputs_0,
  output logic [31:0]          cxu_cmd_payload_inputs_1,
  output logic [2:0]           cxu_cmd_payload_state_id,
  output logic [3:0]           cxu_cmd_payload_cxu_id,
  input  logic                 cxu_rsp_valid,
  output logic                 cxu_rsp_ready,
  input  logic [31:0]          cxu_rsp_payload_outputs_0,
  output logic                 busy,
  output logic                 err_timeout
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DELIVER} state_t;

  typedef struct packed {
    logic [2:0]  fid;
    logic [31:0] a;
    logic [31:0] b;
  } cmd_t;

  state_t              state;
  logic [PW-1:0]       rr_ptr;
  logic [PW-1:0]       owner;
  logic [TW-1:0]       timer;
  cmd_t                cmd;
  logic [31:0]         result;

  logic [NREQ-1:0][2:0]  req_fid;
  logic [NREQ-1:0][31:0] req_a;
  logic [NREQ-1:0][31:0] req_b;
  logic [PW-1:0]         grant_idx;
  logic                  grant_any;
  logic                  grant_en;

  // Slice the flat requester buses and instantiate per-lane handshake decode
  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    assign req_fid[i] = req_function_id[3*i +: 3];
    assign req_a[i]   = req_inputs_0[32*i +: 32];
    assign req_b[i]   = req_inputs_1[32*i +: 32];
    cxu_gf_arbiter_lane #(.PW(PW), .IDX(i)) u_lane (
      .grant_idx (grant_idx),
      .grant_en  (grant_en),
      .owner     (owner),
      .deliver   (state == DELIVER),
      .cmd_ready (req_cmd_ready[i]),
      .rsp_valid (req_rsp_valid[i])
    );
  end

  // Round-robin search from rr_ptr; descending scan so the nearest offset wins
  always_comb begin
    int j;
    j         = 0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = (int'(rr_ptr) + k) % NREQ;
      if (req_cmd_valid[j]) begin
        grant_idx = PW'(j);
        grant_any = 1'b1;
      end
    end
  end

  // Gate with reset so no ready bit escapes while reset is held
  assign grant_en = (state == IDLE) && grant_any && reset;

  assign busy                        = (state != IDLE);
  assign cxu_cmd_valid               = (state == ISSUE);
  assign cxu_rsp_ready               = (state == ISSUE) || (state == WAIT);
  assign cxu_cmd_payload_function_id = cmd.fid;
  assign cxu_cmd_payload_inputs_0    = cmd.a;
  assign cxu_cmd_payload_inputs_1    = cmd.b;
  assign cxu_cmd_payload_state_id    = 3'(STATE_ID);
  assign cxu_cmd_payload_cxu_id      = 4'(CXU_ID);
  assign req_rsp_outputs_0           = result;

  // Sequencer: accept -> issue to CXU -> wait (watchdog) -> deliver to owner
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      owner       <= '0;
      timer       <= '0;
      cmd         <= '0;
      result      <= '0;
      err_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: if (grant_en) begin
          cmd   <= '{fid: req_fid[grant_idx], a: req_a[grant_idx], b: req_b[grant_idx]};
          owner <= grant_idx;
          state <= ISSUE;
        end
        ISSUE: if (cxu_cmd_ready) begin
          if (cxu_rsp_valid) begin
            result <= cxu_rsp_payload_outputs_0;
            state  <= DELIVER;
          end else begin
            timer <= '0;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cxu_rsp_valid) begin
            result <= cxu_rsp_payload_outputs_0;
            state  <= DELIVER;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            result      <= '0;
            err_timeout <= 1'b1;
            state       <= DELIVER;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DELIVER: if (req_rsp_ready[owner]) begin
          rr_ptr <= (owner == PW'(NREQ - 1)) ? '0 : owner + 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cxu_gf_arbiter.sv
// Scoreboard bench for cxu_gf_arbiter: stimulus pushes hand-computed
// expected responses, a negedge monitor pops them on each delivery.
module tb_cxu_gf_arbiter;
  localparam int N = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_cmd_valid, req_cmd_ready, req_rsp_valid, req_rsp_ready;
  logic [3*N-1:0]  req_function_id;
  logic [32*N-1:0] req_inputs_0, req_inputs_1;
  logic [31:0]     req_rsp_outputs_0;
  logic            cxu_cmd_valid, cxu_cmd_ready, cxu_rsp_valid, cxu_rsp_ready;
  logic [2:0]      cxu_cmd_payload_function_id, cxu_cmd_payload_state_id;
  logic [31:0]     cxu_cmd_payload_inputs_0, cxu_cmd_payload_inputs_1;
  logic [3:0]      cxu_cmd_payload_cxu_id;
  logic [31:0]     cxu_rsp_payload_outputs_0;
  logic            busy, err_timeout;
  logic            cxu_hang;

  typedef struct { int idx; logic [31:0] data; } exp_t;
  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  cxu_gf_arbiter #(.NREQ(N), .STATE_ID(0), .CXU_ID(0), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .req_cmd_valid(req_cmd_valid), .req_cmd_ready(req_cmd_ready),
    .req_function_id(req_function_id), .req_inputs_0(req_inputs_0),
    .req_inputs_1(req_inputs_1), .req_rsp_valid(req_rsp_valid),
    .req_rsp_ready(req_rsp_ready), .req_rsp_outputs_0(req_rsp_outputs_0),
    .cxu_cmd_valid(cxu_cmd_valid), .cxu_cmd_ready(cxu_cmd_ready),
    .cxu_cmd_payload_function_id(cxu_cmd_payload_function_id),
    .cxu_cmd_payload_inputs_0(cxu_cmd_payload_inputs_0),
    .cxu_cmd_payload_inputs_1(cxu_cmd_payload_inputs_1),
    .cxu_cmd_payload_state_id(cxu_cmd_payload_state_id),
    .cxu_cmd_payload_cxu_id(cxu_cmd_payload_cxu_id),
    .cxu_rsp_valid(cxu_rsp_valid), .cxu_rsp_ready(cxu_rsp_ready),
    .cxu_rsp_payload_outputs_0(cxu_rsp_payload_outputs_0),
    .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // CXU environment: zero-latency GF(2^8) multiplier (AES poly), or hung
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
    end
    return p;
  endfunction

  always_comb begin
    cxu_rsp_payload_outputs_0 = 32'h0;
    if (cxu_cmd_payload_function_id == 3'd1) begin
      for (int i = 0; i < 4; i++)
        cxu_rsp_payload_outputs_0[8*i +: 8] =
          gmul(cxu_cmd_payload_inputs_0[8*i +: 8], cxu_cmd_payload_inputs_1[8*i +: 8]);
    end else begin
      cxu_rsp_payload_outputs_0[7:0] = gmul(cxu_cmd_payload_inputs_0[7:0], cxu_cmd_payload_inputs_1[7:0]);
    end
  end
  assign cxu_cmd_ready = cxu_hang ? 1'b1 : cxu_rsp_ready;
  assign cxu_rsp_valid = cxu_hang ? 1'b0 : cxu_cmd_valid;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: pop and compare on every response handshake
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b1) begin
      if (|req_rsp_valid) chk("rsp_onehot", $countones(req_rsp_valid), 1);
      for (int i = 0; i < N; i++) begin
        if (req_rsp_valid[i] && req_rsp_ready[i]) begin
          if (q.size() == 0) begin
            chk("unexpected_rsp_req", i, 32'hFFFF_FFFF);
          end else begin
            e = q.pop_front();
            chk("rsp_owner", i, e.idx);
            chk("rsp_data", req_rsp_outputs_0, e.data);
          end
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    req_function_id[3*i +: 3] = f;
    req_inputs_0[32*i +: 32]  = a;
    req_inputs_1[32*i +: 32]  = b;
    req_cmd_valid[i]          = 1'b1;
  endtask

  task automatic push(input int i, input logic [31:0] d);
    exp_t e;
    e.idx  = i;
    e.data = d;
    q.push_back(e);
  endtask

  task automatic drain;
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      tick;
      n++;
    end
    chk("drain", q.size(), 0);
  endtask

  task automatic run_txn(input int i, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] d);
    set_req(i, f, a, b);
    push(i, d);
    tick;
    req_cmd_valid[i] = 1'b0;
    @(negedge clk);
    chk("cmd_fid", cxu_cmd_payload_function_id, f);
    chk("cmd_in0", cxu_cmd_payload_inputs_0, a);
    chk("cmd_in1", cxu_cmd_payload_inputs_1, b);
    drain;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL sim_timeout actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    int order[6] = '{0, 1, 2, 3, 0, 1};
    int g, n, wc;
    reset           = 1'b0;
    cxu_hang        = 1'b0;
    req_cmd_valid   = '1;
    req_rsp_ready   = '1;
    req_function_id = '0;
    req_inputs_0    = '0;
    req_inputs_1    = '0;
    #3;
    // Reset state, with requests pending to prove ready stays low
    chk("rst_busy", busy, 0);
    chk("rst_cmd_ready", req_cmd_ready, 0);
    chk("rst_rsp_valid", req_rsp_valid, 0);
    chk("rst_cxu_cmd_valid", cxu_cmd_valid, 0);
    chk("rst_cxu_rsp_ready", cxu_rsp_ready, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_in0", cxu_cmd_payload_inputs_0, 0);
    chk("rst_out", req_rsp_outputs_0, 0);
    chk("state_id", cxu_cmd_payload_state_id, 0);
    chk("cxu_id", cxu_cmd_payload_cxu_id, 0);
    req_cmd_valid = '0;
    tick;
    reset = 1'b1;

    // 1: single request, latency
    tick;
    set_req(0, 3'd0, 32'h57, 32'h83);
    push(0, 32'h0000_00C1);
    @(negedge clk);
    chk("t1_grant", req_cmd_ready, 4'b0001);
    chk("t1_busy_c0", busy, 0);
    tick;
    req_cmd_valid = '0;
    @(negedge clk);
    chk("t1_busy_c1", busy, 1);
    chk("t1_cxu_valid", cxu_cmd_valid, 1);
    chk("t1_in0", cxu_cmd_payload_inputs_0, 32'h57);
    chk("t1_in1", cxu_cmd_payload_inputs_1, 32'h83);
    chk("t1_ready_c1", req_cmd_ready, 0);
    tick;
    @(negedge clk);
    chk("t1_rsp_c2", req_rsp_valid, 4'b0001);
    chk("t1_busy_c2", busy, 1);
    tick;
    @(negedge clk);
    chk("t1_busy_c3", busy, 0);
    tick;

    // 2: vector request to requester 2
    run_txn(2, 3'd1, 32'h5702_5702, 32'h8387_8387, 32'hC115_C115);

    // 3: fairness from rr_ptr=0
    reset = 1'b0;
    tick;
    reset = 1'b1;
    set_req(0, 3'd0, 32'h02, 32'h87);
    set_req(1, 3'd0, 32'h02, 32'h80);
    set_req(2, 3'd0, 32'h03, 32'h03);
    set_req(3, 3'd0, 32'h57, 32'h83);
    push(0, 32'h15); push(1, 32'h1B); push(2, 32'h05);
    push(3, 32'hC1); push(0, 32'h15); push(1, 32'h1B);
    g = 0;
    n = 0;
    while (g < 6 && n < 60) begin
      @(negedge clk);
      if (|req_cmd_ready) begin
        chk("t3_grant_order", req_cmd_ready, 32'(1) << order[g]);
        g++;
      end
      tick;
      n++;
    end
    req_cmd_valid = '0;
    chk("t3_grants", g, 6);
    drain;

    // 4: backpressure on requester 1, requester 0 waits behind it
    req_rsp_ready[1] = 1'b0;
    set_req(1, 3'd0, 32'h57, 32'h13);
    push(1, 32'h0000_00FE);
    tick;
    req_cmd_valid[1] = 1'b0;
    set_req(0, 3'd1, 32'h0101_0101, 32'hC1C1_C1C1);
    push(0, 32'hC1C1_C1C1);
    tick;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t4_rsp_hold", req_rsp_valid, 4'b0010);
      chk("t4_out_hold", req_rsp_outputs_0, 32'hFE);
      chk("t4_no_grant", req_cmd_ready, 0);
      tick;
    end
    req_rsp_ready[1] = 1'b1;
    tick;
    @(negedge clk);
    chk("t4_next_grant", req_cmd_ready, 4'b0001);
    tick;
    req_cmd_valid = '0;
    drain;

    // 5: watchdog with hung CXU
    cxu_hang = 1'b1;
    chk("t5_err_pre", err_timeout, 0);
    set_req(3, 3'd0, 32'h57, 32'h83);
    push(3, 32'h0);
    tick;
    req_cmd_valid = '0;
    tick;
    wc = 0;
    n  = 0;
    @(negedge clk);
    while (!(|req_rsp_valid) && n < 100) begin
      if (cxu_rsp_ready && !cxu_cmd_valid) wc++;
      tick;
      @(negedge clk);
      n++;
    end
    chk("t5_wait_cycles", wc, 16);
    chk("t5_rsp", req_rsp_valid, 4'b1000);
    chk("t5_err", err_timeout, 1);
    tick;
    cxu_hang = 1'b0;
    run_txn(0, 3'd0, 32'h02, 32'h87, 32'h15);
    chk("t5_err_sticky", err_timeout, 1);

    // 6: reset mid-WAIT discards the transaction
    cxu_hang = 1'b1;
    set_req(2, 3'd0, 32'h11, 32'h22);
    tick;
    req_cmd_valid = '0;
    tick;
    tick;
    tick;
    chk("t6_in_wait", cxu_rsp_ready && !cxu_cmd_valid, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_cxu_rsp_ready", cxu_rsp_ready, 0);
    chk("t6_cxu_cmd_valid", cxu_cmd_valid, 0);
    chk("t6_rsp_valid", req_rsp_valid, 0);
    chk("t6_err", err_timeout, 0);
    cxu_hang = 1'b0;
    tick;
    reset = 1'b1;
    set_req(0, 3'd0, 32'h03, 32'h03);
    set_req(3, 3'd0, 32'h02, 32'h80);
    push(0, 32'h05);
    @(negedge clk);
    chk("t6_grant_rr0", req_cmd_ready, 4'b0001);
    tick;
    req_cmd_valid = '0;
    drain;
    repeat (4) tick;
    chk("t6_no_stray", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
